// File: rtl/icache_if.sv
// Fetch-side and memory-side handshake bundle for the instruction cache.
interface icache_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   if_to_icache_en_in;
  logic [ADDR_WIDTH-1:0]  if_a_in;
  logic                   icache_to_if_en_out;
  logic [INSTR_WIDTH-1:0] if_d_out;
  logic                   icache_to_mem_en_out;
  logic [ADDR_WIDTH-1:0]  icache_a_out;
  logic                   mem_to_icache_en_in;
  logic [INSTR_WIDTH-1:0] mem_d_in;

  // Cache side
  modport slave (
    input  if_to_icache_en_in, if_a_in, mem_to_icache_en_in, mem_d_in,
    output icache_to_if_en_out, if_d_out, icache_to_mem_en_out, icache_a_out
  );

  // Fetch unit / memory controller side
  modport master (
    output if_to_icache_en_in, if_a_in, mem_to_icache_en_in, mem_d_in,
    input  icache_to_if_en_out, if_d_out, icache_to_mem_en_out, icache_a_out
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a single
// outstanding refill.
//
// state | meaning
// IDLE  | accepting fetch requests; hits answered the next cycle
// MISS  | refill request held to memory until the data pulse arrives
module icache #(
  parameter int INDEX_WIDTH = 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  input  logic     clear_branch_in,
  icache_if.slave  bus
);

  localparam int LINES     = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;

  typedef enum logic {IDLE = 1'b0, MISS = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [LINES-1:0]        valid_q;
  logic [TAG_WIDTH-1:0]    tag_mem  [LINES];
  logic [INSTR_WIDTH-1:0]  data_mem [LINES];
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    resp_en_q, resp_en_d;
  logic [INSTR_WIDTH-1:0]  resp_d_q, resp_d_d;
  logic                    fill_we;

  logic [INDEX_WIDTH-1:0]  req_index, miss_index;
  logic [TAG_WIDTH-1:0]    req_tag, miss_tag;
  logic                    hit;

  assign req_index  = bus.if_a_in[INDEX_WIDTH+1:2];
  assign req_tag    = bus.if_a_in[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign miss_index = addr_q[INDEX_WIDTH+1:2];
  assign miss_tag   = addr_q[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign hit        = valid_q[req_index] && (tag_mem[req_index] == req_tag);

  // State register: reset beats flush, flush beats the ready gate
  always_ff @(posedge clk_in) begin
    if (rst_in)
      state_q <= IDLE;
    else if (clear_branch_in)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic; nothing moves while rdy_in is low
  always_comb begin
    state_d = state_q;
    if (rdy_in) begin
      case (state_q)
        IDLE: if (bus.if_to_icache_en_in && !hit) state_d = MISS;
        MISS: if (bus.mem_to_icache_en_in)        state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output/datapath next values; response pulse defaults low when ready
  always_comb begin
    resp_en_d = resp_en_q;
    resp_d_d  = resp_d_q;
    addr_d    = addr_q;
    fill_we   = 1'b0;
    if (rdy_in) begin
      resp_en_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.if_to_icache_en_in) begin
            if (hit) begin
              resp_en_d = 1'b1;
              resp_d_d  = data_mem[req_index];
            end else begin
              addr_d = {bus.if_a_in[ADDR_WIDTH-1:2], 2'b00};
            end
          end
        end
        MISS: begin
          if (bus.mem_to_icache_en_in) begin
            fill_we   = 1'b1;
            resp_en_d = 1'b1;
            resp_d_d  = bus.mem_d_in;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs and miss address; a flush drops any pending response
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      resp_en_q <= 1'b0;
      resp_d_q  <= '0;
      addr_q    <= '0;
    end else if (clear_branch_in) begin
      resp_en_q <= 1'b0;
    end else begin
      resp_en_q <= resp_en_d;
      resp_d_q  <= resp_d_d;
      addr_q    <= addr_d;
    end
  end

  // Valid bits: cleared by reset only, a flush keeps cache contents
  always_ff @(posedge clk_in) begin
    if (rst_in)
      valid_q <= '0;
    else if (fill_we && !clear_branch_in)
      valid_q[miss_index] <= 1'b1;
  end

  // Tag and data storage, written on a completed refill
  always_ff @(posedge clk_in) begin
    if (!rst_in && !clear_branch_in && fill_we) begin
      tag_mem[miss_index]  <= miss_tag;
      data_mem[miss_index] <= bus.mem_d_in;
    end
  end

  assign bus.icache_to_if_en_out  = resp_en_q;
  assign bus.if_d_out             = resp_d_q;
  assign bus.icache_to_mem_en_out = (state_q == MISS);
  assign bus.icache_a_out         = addr_q;

endmodule

// File: tb/tb_icache.sv
module tb_icache;
  localparam int AW = 32;
  localparam int IW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic clear_branch = 1'b0;

  icache_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

  icache #(.INDEX_WIDTH(8), .ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .rdy_in          (rdy),
    .clear_branch_in (clear_branch),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int resp_count = 0;
  logic [IW-1:0] sb [$];

  // Scoreboard: every response pulse must match the oldest expected word
  always @(negedge clk) begin
    if (!rst && bus.icache_to_if_en_out === 1'b1) begin
      resp_count++;
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_resp: got %h with no expected response", bus.if_d_out);
      end else begin
        logic [IW-1:0] exp_d;
        exp_d = sb.pop_front();
        if (bus.if_d_out !== exp_d) begin
          tests_failed++;
          $display("FAIL resp_data: got %h expected %h", bus.if_d_out, exp_d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [AW-1:0] a);
    bus.if_to_icache_en_in = 1'b1;
    bus.if_a_in = a;
    step();
    bus.if_to_icache_en_in = 1'b0;
  endtask

  task automatic mem_reply(input logic [IW-1:0] d, input bit expect_resp);
    if (expect_resp) sb.push_back(d);
    bus.mem_to_icache_en_in = 1'b1;
    bus.mem_d_in = d;
    step();
    bus.mem_to_icache_en_in = 1'b0;
    bus.mem_d_in = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests_run++;
    if (bus.icache_to_if_en_out !== 1'b0 || bus.icache_to_mem_en_out !== 1'b0 ||
        bus.icache_a_out !== '0 || bus.if_d_out !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got resp=%b mem_en=%b a=%h d=%h expected all 0",
               bus.icache_to_if_en_out, bus.icache_to_mem_en_out, bus.icache_a_out, bus.if_d_out);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_miss_refill();
    req(32'h0000_1000);
    tests_run++;
    if (bus.icache_to_mem_en_out !== 1'b1 || bus.icache_a_out !== 32'h1000) begin
      tests_failed++;
      $display("FAIL miss_req: got mem_en=%b a=%h expected 1 00001000",
               bus.icache_to_mem_en_out, bus.icache_a_out);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++;
      if (bus.icache_to_mem_en_out !== 1'b1 || bus.icache_to_if_en_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL miss_wait: got mem_en=%b resp=%b expected 1 0",
                 bus.icache_to_mem_en_out, bus.icache_to_if_en_out);
      end
    end
    mem_reply(32'h00A0_0093, 1'b1);
    tests_run++;
    if (bus.icache_to_if_en_out !== 1'b1 || bus.if_d_out !== 32'h00A0_0093 ||
        bus.icache_to_mem_en_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL refill_resp: got resp=%b d=%h mem_en=%b expected 1 00a00093 0",
               bus.icache_to_if_en_out, bus.if_d_out, bus.icache_to_mem_en_out);
    end
    step();
    tests_run++;
    if (bus.icache_to_if_en_out !== 1'b0 || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL refill_pulse: got resp=%b pending=%0d expected 0 0",
               bus.icache_to_if_en_out, sb.size());
    end
  endtask

  task automatic test_hit();
    sb.push_back(32'h00A0_0093);
    req(32'h0000_1000);
    tests_run++;
    if (bus.icache_to_if_en_out !== 1'b1 || bus.if_d_out !== 32'h00A0_0093 ||
        bus.icache_to_mem_en_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL hit: got resp=%b d=%h mem_en=%b expected 1 00a00093 0",
               bus.icache_to_if_en_out, bus.if_d_out, bus.icache_to_mem_en_out);
    end
    step();
    tests_run++;
    if (bus.icache_to_if_en_out !== 1'b0 || bus.icache_to_mem_en_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL hit_pulse: got resp=%b mem_en=%b expected 0 0",
               bus.icache_to_if_en_out, bus.icache_to_mem_en_out);
    end
  endtask

  task automatic test_back_to_back();
    int rc0;
    rc0 = resp_count;
    sb.push_back(32'h00A0_0093);
    sb.push_back(32'h00A0_0093);
    bus.if_to_icache_en_in = 1'b1;
    bus.if_a_in = 32'h0000_1000;
    step();
    bus.if_a_in = 32'h0000_1003;
    step();
    bus.if_to_icache_en_in = 1'b0;
    @(negedge clk);
    #1;
    tests_run++;
    if (resp_count != rc0 + 2 || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL back_to_back: got %0d responses expected 2", resp_count - rc0);
    end
  endtask

  task automatic test_conflict();
    req(32'h0000_1400);
    tests_run++;
    if (bus.icache_to_mem_en_out !== 1'b1 || bus.icache_a_out !== 32'h1400 ||
        bus.icache_to_if_en_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL conflict_miss: got mem_en=%b a=%h resp=%b expected 1 00001400 0",
               bus.icache_to_mem_en_out, bus.icache_a_out, bus.icache_to_if_en_out);
    end
    step();
    mem_reply(32'h1234_5678, 1'b1);
    step();
    req(32'h0000_1000);
    tests_run++;
    if (bus.icache_to_mem_en_out !== 1'b1 || bus.icache_a_out !== 32'h1000 ||
        bus.icache_to_if_en_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL evicted_miss: got mem_en=%b a=%h resp=%b expected 1 00001000 0",
               bus.icache_to_mem_en_out, bus.icache_a_out, bus.icache_to_if_en_out);
    end
    // A second request while a refill is outstanding must be ignored
    req(32'h0000_3000);
    tests_run++;
    if (bus.icache_to_mem_en_out !== 1'b1 || bus.icache_a_out !== 32'h1000) begin
      tests_failed++;
      $display("FAIL miss_ignores_req: got mem_en=%b a=%h expected 1 00001000",
               bus.icache_to_mem_en_out, bus.icache_a_out);
    end
    mem_reply(32'h00A0_0093, 1'b1);
    step();
  endtask

  task automatic test_clear();
    int rc0;
    req(32'h0000_2000);
    step();
    clear_branch = 1'b1;
    step();
    clear_branch = 1'b0;
    tests_run++;
    if (bus.icache_to_mem_en_out !== 1'b0 || bus.icache_to_if_en_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_abort: got mem_en=%b resp=%b expected 0 0",
               bus.icache_to_mem_en_out, bus.icache_to_if_en_out);
    end
    rc0 = resp_count;
    mem_reply(32'h5555_AAAA, 1'b0);
    step();
    tests_run++;
    if (resp_count != rc0) begin
      tests_failed++;
      $display("FAIL clear_stale_refill: got %0d responses expected 0", resp_count - rc0);
    end
    req(32'h0000_2000);
    tests_run++;
    if (bus.icache_to_mem_en_out !== 1'b1 || bus.icache_a_out !== 32'h2000) begin
      tests_failed++;
      $display("FAIL clear_rerequest: got mem_en=%b a=%h expected 1 00002000",
               bus.icache_to_mem_en_out, bus.icache_a_out);
    end
    mem_reply(32'hDEAD_BEEF, 1'b1);
    step();
  endtask

  task automatic test_rdy_hold();
    int rc0;
    req(32'h0000_3000);
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (bus.icache_to_mem_en_out !== 1'b1 || bus.icache_a_out !== 32'h3000) begin
        tests_failed++;
        $display("FAIL rdy_hold: got mem_en=%b a=%h expected 1 00003000",
                 bus.icache_to_mem_en_out, bus.icache_a_out);
      end
    end
    rdy = 1'b1;
    step();
    mem_reply(32'hCAFE_F00D, 1'b1);
    tests_run++;
    if (bus.icache_to_if_en_out !== 1'b1 || bus.if_d_out !== 32'hCAFE_F00D ||
        bus.icache_to_mem_en_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL rdy_refill: got resp=%b d=%h mem_en=%b expected 1 cafef00d 0",
               bus.icache_to_if_en_out, bus.if_d_out, bus.icache_to_mem_en_out);
    end
    step();
    // A refill pulse while idle must neither respond nor overwrite the line
    rc0 = resp_count;
    mem_reply(32'h1111_1111, 1'b0);
    step();
    tests_run++;
    if (resp_count != rc0) begin
      tests_failed++;
      $display("FAIL idle_refill_resp: got %0d responses expected 0", resp_count - rc0);
    end
    sb.push_back(32'hCAFE_F00D);
    req(32'h0000_3000);
    tests_run++;
    if (bus.icache_to_if_en_out !== 1'b1 || bus.if_d_out !== 32'hCAFE_F00D) begin
      tests_failed++;
      $display("FAIL idle_refill_line: got resp=%b d=%h expected 1 cafef00d",
               bus.icache_to_if_en_out, bus.if_d_out);
    end
    step();
  endtask

  task automatic test_reset_mid_miss();
    int rc0;
    req(32'h0000_1000);
    mem_reply(32'h00A0_0093, 1'b1);
    step();
    sb.push_back(32'h00A0_0093);
    req(32'h0000_1000);
    step();
    req(32'h0000_5000);
    step();
    rst = 1'b1;
    step();
    tests_run++;
    if (bus.icache_to_if_en_out !== 1'b0 || bus.icache_to_mem_en_out !== 1'b0 ||
        bus.icache_a_out !== '0 || bus.if_d_out !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_miss: got resp=%b mem_en=%b a=%h d=%h expected all 0",
               bus.icache_to_if_en_out, bus.icache_to_mem_en_out, bus.icache_a_out, bus.if_d_out);
    end
    rst = 1'b0;
    step();
    rc0 = resp_count;
    mem_reply(32'h7777_7777, 1'b0);
    step();
    tests_run++;
    if (resp_count != rc0 || bus.icache_to_mem_en_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_late_refill: got %0d responses mem_en=%b expected 0 0",
               resp_count - rc0, bus.icache_to_mem_en_out);
    end
    req(32'h0000_1000);
    tests_run++;
    if (bus.icache_to_mem_en_out !== 1'b1 || bus.icache_to_if_en_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_invalidates: got mem_en=%b resp=%b expected 1 0",
               bus.icache_to_mem_en_out, bus.icache_to_if_en_out);
    end
    mem_reply(32'h00A0_0093, 1'b1);
    step();
    step();
  endtask

  initial begin
    bus.if_to_icache_en_in = 1'b0;
    bus.if_a_in = '0;
    bus.mem_to_icache_en_in = 1'b0;
    bus.mem_d_in = '0;
    test_reset();
    test_miss_refill();
    test_hit();
    test_back_to_back();
    test_conflict();
    test_clear();
    test_rdy_hold();
    test_reset_mid_miss();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 8, log2 of the number of direct-mapped one-word lines (256 lines).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter INSTR_WIDTH, default 32, instruction word width.
REQ-004 SHALL have port clk_in  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst_in  input  1  synchronous active-high reset.
REQ-006 SHALL have port rdy_in  input  1  global ready; when low, state holds except for reset and clear.
REQ-007 SHALL have port if_to_icache_en_in  input  1  fetch request valid, single-cycle pulse.
REQ-008 SHALL have port if_a_in  input  ADDR_WIDTH  fetch byte address, sampled with the request.
REQ-009 SHALL have port icache_to_if_en_out  output  1  response valid, single-cycle pulse.
REQ-010 SHALL have port if_d_out  output  INSTR_WIDTH  instruction word, valid when icache_to_if_en_out is high.
REQ-011 SHALL have port icache_to_mem_en_out  output  1  refill request level to the memory controller.
REQ-012 SHALL have port icache_a_out  output  ADDR_WIDTH  refill word address, with bits [1:0] forced to 0.
REQ-013 SHALL have port mem_to_icache_en_in  input  1  refill data valid pulse.
REQ-014 SHALL have port mem_d_in  input  INSTR_WIDTH  refill word, little-endian instruction.
REQ-015 SHALL have port clear_branch_in  input  1  misprediction flush; aborts any outstanding fetch.

Function
REQ-016 SHALL decode each address as: offset = a[1:0] (ignored), index = a[INDEX_WIDTH+1:2], tag = a[ADDR_WIDTH-1:INDEX_WIDTH+2].
REQ-017 SHALL store per line one valid bit, one tag and one data word; a hit is a valid line whose stored tag equals the request tag.
REQ-018 SHALL implement an FSM with two states, IDLE and MISS, and SHALL accept requests only in IDLE.
REQ-019 On a request in IDLE that hits, SHALL drive the line data on if_d_out and pulse icache_to_if_en_out in the cycle after the request, then remain in IDLE.
REQ-020 On a request in IDLE that misses, SHALL latch the address, go to MISS, and assert icache_to_mem_en_out with icache_a_out from the next cycle.
REQ-021 In MISS, SHALL hold icache_to_mem_en_out high and icache_a_out stable until mem_to_icache_en_in is sampled high.
REQ-022 At the edge where mem_to_icache_en_in is sampled in MISS, SHALL in that same edge:
- write valid, tag and mem_d_in into the line;
- drive mem_d_in on if_d_out;
- pulse icache_to_if_en_out;
- deassert icache_to_mem_en_out;
- return to IDLE.
REQ-023 SHALL ignore if_to_icache_en_in while in MISS; one outstanding fetch is the protocol maximum.
REQ-024 SHALL ignore mem_to_icache_en_in while in IDLE; no line is written.
REQ-025 SHALL hold icache_to_if_en_out high for exactly one cycle per response and low otherwise.
REQ-026 On clear_branch_in high, regardless of rdy_in, SHALL at that edge:
- go to IDLE;
- deassert icache_to_mem_en_out and icache_to_if_en_out;
- discard any request or refill sampled in the same cycle;
- retain cache contents.
REQ-027 SHALL give priority rst_in > clear_branch_in > rdy_in-gated operation.
REQ-028 While rdy_in is low, SHALL hold all outputs and state, and SHALL not sample requests or refills.

Reset
REQ-029 On rst_in, SHALL clear all valid bits, enter IDLE, drive icache_to_if_en_out=0, icache_to_mem_en_out=0, icache_a_out=0 and if_d_out=0.
REQ-030 Reset asserted in MISS SHALL abandon the refill; a later mem_to_icache_en_in SHALL be ignored under REQ-024.

Verification
REQ-031 After reset, request a=0x0000_1000 -> next cycle mem_en=1, icache_a_out=0x1000; mem returns 0x00A00093 after 3 cycles -> same edge resp pulse, if_d_out=0x00A00093, mem_en=0.
REQ-032 Repeat a=0x1000 -> resp pulse the very next cycle with 0x00A00093 and mem_en stays 0.
REQ-033 Conflict: a=0x0000_1400 (same index, tag differs) -> miss, refill 0x12345678; then a=0x1000 -> miss again.
REQ-034 Miss on 0x2000, then clear_branch_in 1 cycle later, then mem pulse -> no resp pulse, line not valid; re-request 0x2000 -> miss.
REQ-035 Hold rdy_in=0 during a MISS while mem pulse is absent, then raise it -> mem_en and address unchanged throughout and the refill completes normally.
REQ-036 Assert rst_in mid-MISS -> all outputs 0 next cycle; previously cached 0x1000 -> misses after reset.
